// File: rtl/dl16_pkg.sv
// DLFloat16 shared definitions: field layout, special encodings, flag indices.
package dl16_pkg;

  localparam int unsigned EXP_W    = 6;
  localparam int unsigned FRAC_W   = 9;
  localparam int unsigned SIGN_BIT = EXP_W + FRAC_W;

  localparam int unsigned BIAS     = 31;
  localparam int unsigned EXP_MAX  = (1 << EXP_W) - 1;

  localparam logic [15:0] DL_NAN   = 16'hFFFF;
  localparam logic [15:0] DL_ZERO  = 16'h0000;

  localparam int unsigned FLAG_NAN = 2;
  localparam int unsigned FLAG_OVF = 1;
  localparam int unsigned FLAG_INX = 0;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_NAN
  } dl_class_e;

  // All-ones exponent+fraction encodes NaN/Inf; zero exponent is zero (no subnormals).
  function automatic dl_class_e dl_classify(input logic [EXP_W-1:0] exp_f,
                                            input logic [FRAC_W-1:0] frac_f);
    if (&{exp_f, frac_f})
      return CLS_NAN;
    else if (exp_f == '0)
      return CLS_ZERO;
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/dl_rne_round.sv
// Round-to-nearest-even of a 9-bit fraction with extension bits; reports overflow/inexact.
module dl_rne_round
  import dl16_pkg::*;
#(
  parameter int unsigned EXT_W = 4
) (
  input  logic [FRAC_W-1:0] frac,
  input  logic [EXT_W-1:0]  ext,
  input  logic [EXP_W-1:0]  exp_in,
  output logic [FRAC_W-1:0] frac_r,
  output logic [EXP_W:0]    exp_r,
  output logic              ovf,
  output logic              inx
);

  logic            g, r, s, inc;
  logic [FRAC_W:0] sum;

  // Guard/round/sticky increment, carry into exponent, and overflow detection.
  always_comb begin
    g   = ext[EXT_W-1];
    r   = ext[EXT_W-2];
    s   = |ext[EXT_W-3:0];
    inc = g & (r | s | frac[0]);
    sum = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
    if (sum[FRAC_W]) begin
      frac_r = '0;
      exp_r  = {1'b0, exp_in} + {{EXP_W{1'b0}}, 1'b1};
    end else begin
      frac_r = sum[FRAC_W-1:0];
      exp_r  = {1'b0, exp_in};
    end
    ovf = (exp_r > (EXP_W+1)'(EXP_MAX)) ||
          ((exp_r == (EXP_W+1)'(EXP_MAX)) && (frac_r == '1));
    inx = |ext;
  end

endmodule

// File: rtl/dl_round_pack.sv
// DLFloat16 output stage: two-stage valid/ready pipeline, RNE rounding, packing, sticky flags.
module dl_round_pack
  import dl16_pkg::*;
#(
  parameter int unsigned EXT_W  = 4,
  parameter int unsigned FLAG_W = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_W+FRAC_W+EXT_W:0]    in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [15:0]                    out_data,
  output logic [FLAG_W-1:0]              out_flags,
  output logic [FLAG_W-1:0]              sticky_flags,
  input  logic                           flag_clr
);

  localparam int unsigned IN_W = EXP_W + FRAC_W + EXT_W + 1;

  logic              v1, v2;
  logic              adv1, adv2;
  logic [IN_W-1:0]   d1;

  logic              sign1;
  logic [EXP_W-1:0]  exp1;
  logic [FRAC_W-1:0] frac1;
  logic [EXT_W-1:0]  ext1;
  dl_class_e         cls1;

  logic [FRAC_W-1:0] frac_r;
  logic [EXP_W:0]    exp_r;
  logic              ovf_r, inx_r;

  logic [15:0]       nxt_data;
  logic [FLAG_W-1:0] nxt_flags;

  // Stage advance: each stage moves when empty or when the stage after it moves.
  always_comb begin
    adv2     = ~v2 | out_ready;
    adv1     = ~v1 | adv2;
    in_ready = adv1;
  end

  // S1 field extraction and class decode.
  always_comb begin
    {sign1, exp1, frac1, ext1} = d1;
    cls1 = dl_classify(exp1, frac1);
  end

  dl_rne_round #(.EXT_W(EXT_W)) u_round (
    .frac   (frac1),
    .ext    (ext1),
    .exp_in (exp1),
    .frac_r (frac_r),
    .exp_r  (exp_r),
    .ovf    (ovf_r),
    .inx    (inx_r)
  );

  // Result selection: NaN, then zero (sign dropped), then overflow, then normal.
  always_comb begin
    nxt_data  = {sign1, exp_r[EXP_W-1:0], frac_r};
    nxt_flags = '0;
    if (cls1 == CLS_NAN) begin
      nxt_data            = DL_NAN;
      nxt_flags[FLAG_NAN] = 1'b1;
    end else if (cls1 == CLS_ZERO) begin
      nxt_data            = DL_ZERO;
    end else if (ovf_r) begin
      nxt_data            = DL_NAN;
      nxt_flags[FLAG_OVF] = 1'b1;
      nxt_flags[FLAG_INX] = 1'b1;
    end else begin
      nxt_flags[FLAG_INX] = inx_r;
    end
  end

  // S1 register: captures the incoming word.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid)
        d1 <= in_data;
    end
  end

  // S2 register: holds the packed result and its flags until taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_data  <= nxt_data;
        out_flags <= nxt_flags;
      end
    end
  end

  // Sticky accumulation on delivered results; clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst)
      sticky_flags <= '0;
    else if (flag_clr)
      sticky_flags <= '0;
    else if (v2 && out_ready)
      sticky_flags <= sticky_flags | out_flags;
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_dl_round_pack.sv
// Directed self-checking bench for dl_round_pack.
module tb_dl_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_flags;
  logic [2:0]  sticky_flags;
  logic        flag_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dl_round_pack #(.EXT_W(4), .FLAG_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flag_clr     (flag_clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flag_clr = 1'b0;
    tick; tick;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_out_flags: got %b expected 000", out_flags); end
    checks++; if (sticky_flags !== 3'b000) begin errors++; $display("FAIL reset_sticky: got %b expected 000", sticky_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  // One word through an idle pipeline with out_ready held high.
  task automatic send_one(input string name, input logic [19:0] d, input logic [15:0] exp_d,
                          input logic [2:0] exp_f, input logic [2:0] exp_s);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_latency_early: got out_valid %b expected 0", name, out_valid); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid: got %b expected 1", name, out_valid); end
    checks++; if (out_data !== exp_d) begin errors++; $display("FAIL %s_data: got %h expected %h", name, out_data, exp_d); end
    checks++; if (out_flags !== exp_f) begin errors++; $display("FAIL %s_flags: got %b expected %b", name, out_flags, exp_f); end
    tick;
    checks++; if (sticky_flags !== exp_s) begin errors++; $display("FAIL %s_sticky: got %b expected %b", name, sticky_flags, exp_s); end
  endtask

  task automatic test_rounding;
    send_one("exact",    20'h3E000, 16'h3E00, 3'b000, 3'b000);
    send_one("tie_up",   20'h3E018, 16'h3E02, 3'b001, 3'b001);
    send_one("tie_even", 20'h3E008, 16'h3E00, 3'b001, 3'b001);
    send_one("carry",    20'h3FFFC, 16'h4000, 3'b001, 3'b001);
    send_one("overflow", 20'h7FFEC, 16'hFFFF, 3'b011, 3'b011);
  endtask

  task automatic test_specials;
    send_one("nan",      20'hFFFFF, 16'hFFFF, 3'b100, 3'b111);
    send_one("neg_zero", 20'h80000, 16'h0000, 3'b000, 3'b111);
  endtask

  task automatic test_back_to_back;
    logic [19:0] words [4];
    logic [15:0] exp_d [4];
    logic [2:0]  exp_f [4];
    int sent = 0;
    int rcv  = 0;
    logic in_fire;
    words[0] = 20'h3E000; exp_d[0] = 16'h3E00; exp_f[0] = 3'b000;
    words[1] = 20'h3E018; exp_d[1] = 16'h3E02; exp_f[1] = 3'b001;
    words[2] = 20'h3FFFC; exp_d[2] = 16'h4000; exp_f[2] = 3'b001;
    words[3] = 20'h40010; exp_d[3] = 16'h4001; exp_f[3] = 3'b000;
    for (int cyc = 0; cyc < 14; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 4);
      in_data   = (sent < 4) ? words[sent] : 20'h0;
      #3;
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready c%0d: got %b expected 0", cyc, in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h3E00) begin errors++;
          $display("FAIL b2b_stall_hold c%0d: got v=%b d=%h expected v=1 d=3e00", cyc, out_valid, out_data); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (rcv >= 4) begin errors++; $display("FAIL b2b_extra_output: got %h expected none", out_data); end
        else if (out_data !== exp_d[rcv] || out_flags !== exp_f[rcv]) begin errors++;
          $display("FAIL b2b_order #%0d: got %h/%b expected %h/%b", rcv, out_data, out_flags, exp_d[rcv], exp_f[rcv]); end
        rcv++;
      end
      in_fire = in_valid && in_ready;
      tick;
      if (in_fire) sent++;
    end
    in_valid = 1'b0;
    checks++; if (sent !== 4) begin errors++; $display("FAIL b2b_sent: got %0d expected 4", sent); end
    checks++; if (rcv !== 4) begin errors++; $display("FAIL b2b_received: got %0d expected 4", rcv); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_reset_in_flight;
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 20'h3E018;
    tick;
    in_data = 20'h3FFFC;
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
      $display("FAIL rif_full: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rif_out_valid: got %b expected 0", out_valid); end
    checks++; if (sticky_flags !== 3'b000) begin errors++; $display("FAIL rif_sticky: got %b expected 000", sticky_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rif_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rif_out_data: got %h expected 0000", out_data); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rif_dropped: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_flag_clr;
    out_ready = 1'b1;
    in_valid  = 1'b1; in_data = 20'h3E018;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b1 || out_flags !== 3'b001) begin errors++;
      $display("FAIL clr_pre: got v=%b f=%b expected v=1 f=001", out_valid, out_flags); end
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;
    checks++; if (sticky_flags !== 3'b000) begin errors++; $display("FAIL clr_priority: got %b expected 000", sticky_flags); end
    send_one("post_clr", 20'h3E008, 16'h3E00, 3'b001, 3'b001);
  endtask

  initial begin
    test_reset;
    test_rounding;
    test_specials;
    test_back_to_back;
    test_reset_in_flight;
    test_flag_clr;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
